// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between instruction fetch (F)
// and load/store (L); read data is steered back to its issuer after MEM_LAT cycles.
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_halt,
    // fetch requester
    input  logic          i_f_req,
    input  logic [AW-1:0] i_f_addr,
    output logic          o_f_gnt,
    output logic          o_f_rvalid,
    output logic [DW-1:0] o_f_rdata,
    // load/store requester
    input  logic          i_l_req,
    input  logic          i_l_we,
    input  logic [AW-1:0] i_l_addr,
    input  logic [DW-1:0] i_l_wdata,
    output logic          o_l_gnt,
    output logic          o_l_rvalid,
    output logic [DW-1:0] o_l_rdata,
    // memory port
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata,
    // status
    output logic          o_busy,
    output logic [15:0]   o_conflicts
);

    localparam logic OWN_F = 1'b0;
    localparam logic OWN_L = 1'b1;

    logic               r_last_own;
    logic [MEM_LAT-1:0] r_pipe_vld;
    logic [MEM_LAT-1:0] r_pipe_own;
    logic [15:0]        r_conflicts;

    logic               w_run;
    logic               w_both_req;
    logic               w_f_gnt;
    logic               w_l_gnt;
    logic               w_rd_issue;
    logic [MEM_LAT-1:0] w_vld_shift;
    logic [MEM_LAT-1:0] w_own_shift;
    logic               w_out_vld;
    logic               w_out_own;

    // Grants are held off during reset as well as halt so nothing can be strobed
    // into the memory while state is being cleared.
    assign w_run      = i_rst_n & ~i_halt;
    assign w_both_req = i_f_req & i_l_req;

    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (w_run) begin
            if (w_both_req) begin
                w_f_gnt = (r_last_own == OWN_L);
                w_l_gnt = (r_last_own == OWN_F);
            end else begin
                w_f_gnt = i_f_req;
                w_l_gnt = i_l_req;
            end
        end
    end

    assign o_f_gnt = w_f_gnt;
    assign o_l_gnt = w_l_gnt;

    assign w_rd_issue = w_f_gnt | (w_l_gnt & ~i_l_we);

    always_comb begin
        o_mem_en    = w_f_gnt | w_l_gnt;
        o_mem_we    = w_l_gnt & i_l_we;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_f_gnt) begin
            o_mem_addr = i_f_addr;
        end else if (w_l_gnt) begin
            o_mem_addr  = i_l_addr;
            o_mem_wdata = i_l_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_own <= OWN_L;
        end else if (w_f_gnt) begin
            r_last_own <= OWN_F;
        end else if (w_l_gnt) begin
            r_last_own <= OWN_L;
        end
    end

    // Response pipeline: stage 0 captures the issuing grant, the last stage
    // lines up with mem_rdata. Writes enter as bubbles.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign w_vld_shift[gi] = w_rd_issue;
                assign w_own_shift[gi] = w_l_gnt;
            end else begin : g_tail
                assign w_vld_shift[gi] = r_pipe_vld[gi-1];
                assign w_own_shift[gi] = r_pipe_own[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pipe_vld <= '0;
            r_pipe_own <= '0;
        end else begin
            r_pipe_vld <= w_vld_shift;
            r_pipe_own <= w_own_shift;
        end
    end

    assign w_out_vld = r_pipe_vld[MEM_LAT-1];
    assign w_out_own = r_pipe_own[MEM_LAT-1];

    assign o_f_rvalid = w_out_vld & (w_out_own == OWN_F);
    assign o_l_rvalid = w_out_vld & (w_out_own == OWN_L);
    assign o_f_rdata  = o_f_rvalid ? i_mem_rdata : '0;
    assign o_l_rdata  = o_l_rvalid ? i_mem_rdata : '0;
    assign o_busy     = |r_pipe_vld;

    // Counts contention even when the loser is about to be served next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_conflicts <= '0;
        end else if (w_both_req && !i_halt && (r_conflicts != 16'hFFFF)) begin
            r_conflicts <= r_conflicts + 16'd1;
        end
    end

    assign o_conflicts = r_conflicts;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives two arbiters (MEM_LAT 1 and 3) with identical requests and checks them
// against a round-robin reference model and a response scoreboard.
module tb_mem_port_arbiter;

    typedef struct {
        int          due;
        logic        own;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = '0;
    logic        l_req = 1'b0;
    logic        l_we = 1'b0;
    logic [15:0] l_addr = '0;
    logic [15:0] l_wdata = '0;

    logic        f_gnt[2], f_rvalid[2], l_gnt[2], l_rvalid[2];
    logic        mem_en[2], mem_we[2], busy[2];
    logic [15:0] f_rdata[2], l_rdata[2], mem_addr[2], mem_wdata[2];
    logic [15:0] mem_rdata[2], conflicts[2];

    logic [15:0] env_mem[256];
    logic [15:0] model_mem[256];
    logic [15:0] rp1;
    logic [15:0] rp3[3];

    exp_t        q0[$];
    exp_t        q1[$];
    logic        m_last_l = 1'b1;
    logic [15:0] m_conf = '0;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt[0]),
        .o_f_rvalid(f_rvalid[0]), .o_f_rdata(f_rdata[0]),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
        .o_l_gnt(l_gnt[0]), .o_l_rvalid(l_rvalid[0]), .o_l_rdata(l_rdata[0]),
        .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]),
        .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0]),
        .o_busy(busy[0]), .o_conflicts(conflicts[0])
    );

    mem_port_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt),
        .i_f_req(f_req), .i_f_addr(f_addr), .o_f_gnt(f_gnt[1]),
        .o_f_rvalid(f_rvalid[1]), .o_f_rdata(f_rdata[1]),
        .i_l_req(l_req), .i_l_we(l_we), .i_l_addr(l_addr), .i_l_wdata(l_wdata),
        .o_l_gnt(l_gnt[1]), .o_l_rvalid(l_rvalid[1]), .o_l_rdata(l_rdata[1]),
        .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]),
        .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1]),
        .o_busy(busy[1]), .o_conflicts(conflicts[1])
    );

    // Memory environment: writes from the LAT=1 port, reads delayed per instance.
    // Non-read cycles return junk so un-gated rdata shows up.
    always @(posedge clk) begin
        if (mem_en[0] && mem_we[0]) env_mem[mem_addr[0][7:0]] <= mem_wdata[0];
        rp1    <= (mem_en[0] && !mem_we[0]) ? env_mem[mem_addr[0][7:0]] : 16'hDEAD;
        rp3[0] <= (mem_en[1] && !mem_we[1]) ? env_mem[mem_addr[1][7:0]] : 16'hDEAD;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign mem_rdata[0] = rp1;
    assign mem_rdata[1] = rp3[2];

    // One clock cycle: check responses due now, drive the request, check the
    // combinational port against the model, then log expected read returns.
    task automatic step(input logic f, input logic [15:0] fa, input logic l,
                        input logic we, input logic [15:0] la, input logic [15:0] wd,
                        input logic h);
        exp_t        e;
        logic        hit, bsy, fg, lg;
        logic [34:0] xr;
        logic [35:0] xp;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            hit = 1'b0;
            e   = '{0, 1'b0, 16'h0};
            if (k == 0) begin
                bsy = (q0.size() != 0);
                if (bsy && q0[0].due == cyc) begin e = q0.pop_front(); hit = 1'b1; end
            end else begin
                bsy = (q1.size() != 0);
                if (bsy && q1[0].due == cyc) begin e = q1.pop_front(); hit = 1'b1; end
            end
            xr = {hit && !e.own, hit && e.own, (hit && !e.own) ? e.data : 16'h0,
                  (hit && e.own) ? e.data : 16'h0, bsy};
            vectors++;
            if ({f_rvalid[k], l_rvalid[k], f_rdata[k], l_rdata[k], busy[k]} !== xr) begin
                miscompares++;
                $display("FAIL response dut%0d cyc %0d: got {frv,lrv,frd,lrd,busy}=%h required %h",
                         k, cyc, {f_rvalid[k], l_rvalid[k], f_rdata[k], l_rdata[k], busy[k]}, xr);
            end
            vectors++;
            if (conflicts[k] !== m_conf) begin
                miscompares++;
                $display("FAIL conflicts dut%0d cyc %0d: got %h required %h",
                         k, cyc, conflicts[k], m_conf);
            end
        end
        f_req = f; f_addr = fa; l_req = l; l_we = we; l_addr = la; l_wdata = wd; halt = h;
        #1;
        fg = !h && f && (!l || m_last_l);
        lg = !h && l && (!f || !m_last_l);
        xp = {fg, lg, fg | lg, lg & we, fg ? fa : (lg ? la : 16'h0), lg ? wd : 16'h0};
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({f_gnt[k], l_gnt[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k]} !== xp) begin
                miscompares++;
                $display("FAIL port dut%0d cyc %0d: got {fg,lg,en,we,addr,wdata}=%h required %h",
                         k, cyc, {f_gnt[k], l_gnt[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k]}, xp);
            end
        end
        if (fg) begin
            q0.push_back('{cyc + 1, 1'b0, model_mem[fa[7:0]]});
            q1.push_back('{cyc + 3, 1'b0, model_mem[fa[7:0]]});
        end else if (lg && !we) begin
            q0.push_back('{cyc + 1, 1'b1, model_mem[la[7:0]]});
            q1.push_back('{cyc + 3, 1'b1, model_mem[la[7:0]]});
        end else if (lg && we) begin
            model_mem[la[7:0]] = wd;
        end
        if (fg) m_last_l = 1'b0;
        else if (lg) m_last_l = 1'b1;
        if (f && l && !h && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; f_req = 1'b1; l_req = 1'b1; f_addr = 16'h0011; l_addr = 16'h0022;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({f_gnt[k], l_gnt[k], mem_en[k], f_rvalid[k], l_rvalid[k], busy[k],
                 conflicts[k], f_rdata[k], l_rdata[k]} !== 54'h0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d: got %h required 0", k,
                         {f_gnt[k], l_gnt[k], mem_en[k], f_rvalid[k], l_rvalid[k], busy[k],
                          conflicts[k], f_rdata[k], l_rdata[k]});
            end
        end
        f_req = 1'b0; l_req = 1'b0;
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
        idle(4);
    endtask

    task automatic test_f_read();
        step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        idle(4);
    endtask

    task automatic test_store();
        step(1'b0, 16'h0, 1'b1, 1'b1, 16'h0030, 16'h1234, 1'b0);
        idle(4);
        step(1'b1, 16'h0030, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h5555, 1'b0);
        idle(4);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0050 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0060 + 16'(i), 16'h0, 1'b0);
        idle(4);
    endtask

    task automatic test_halt();
        step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0044, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b1, 16'h0044, 1'b1, 1'b0, 16'h0070, 16'h0, 1'b1);
        step(1'b1, 16'h0044, 1'b1, 1'b0, 16'h0070, 16'h0, 1'b0);
        step(1'b1, 16'h0045, 1'b1, 1'b0, 16'h0070, 16'h0, 1'b0);
        idle(4);
    endtask

    task automatic test_reset_flight();
        step(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({f_rvalid[k], l_rvalid[k], f_rdata[k], l_rdata[k], busy[k], conflicts[k],
                 f_gnt[k], l_gnt[k]} !== 52'h0) begin
                miscompares++;
                $display("FAIL async_reset dut%0d: got %h required 0", k,
                         {f_rvalid[k], l_rvalid[k], f_rdata[k], l_rdata[k], busy[k], conflicts[k],
                          f_gnt[k], l_gnt[k]});
            end
        end
        q0.delete(); q1.delete();
        m_last_l = 1'b1; m_conf = 16'h0;
        f_req = 1'b0; l_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        step(1'b1, 16'h0012, 1'b1, 1'b0, 16'h0024, 16'h0, 1'b0);
        idle(4);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 65540; i++)
            step(1'b1, 16'(i), 1'b1, 1'b0, 16'(i * 3), 16'h0, 1'b0);
        idle(4);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (conflicts[k] !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL saturate dut%0d: got %h required ffff", k, conflicts[k]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            env_mem[i]   = {i[7:0], ~i[7:0]};
            model_mem[i] = {i[7:0], ~i[7:0]};
        end
        env_mem[16]   = 16'hBEEF;
        model_mem[16] = 16'hBEEF;
        test_reset();
        test_round_robin();
        test_f_read();
        test_store();
        test_back_to_back();
        test_halt();
        test_reset_flight();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single 16-bit data-memory port between two requesters: the instruction-fetch unit (F) and the load/store unit (L).
- Arbitrates with round-robin priority and issues at most one memory access per cycle.
- Routes read data back to the requester that issued the read, after a fixed memory latency.
- Sits between the processor control FSM and the memory array. Provides halt gating, a busy indication and a saturating conflict counter.

Parameters:
- AW, 16: address width in bits.
- DW, 16: data word width in bits.
- MEM_LAT, 1: cycles from an issued read to valid mem_rdata; legal range 1..4.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- halt, input, 1: when high, no new grants are issued.
- f_req, input, 1: fetch read request.
- f_addr, input, AW: fetch address.
- f_gnt, output, 1: fetch request accepted this cycle.
- f_rvalid, output, 1: fetch read data valid.
- f_rdata, output, DW: fetch read data.
- l_req, input, 1: load/store request.
- l_we, input, 1: 1 = store, 0 = load.
- l_addr, input, AW: load/store address.
- l_wdata, input, DW: store data.
- l_gnt, output, 1: load/store request accepted this cycle.
- l_rvalid, output, 1: load data valid.
- l_rdata, output, DW: load data.
- mem_en, output, 1: memory access strobe.
- mem_we, output, 1: memory write enable.
- mem_addr, output, AW: memory address.
- mem_wdata, output, DW: memory write data.
- mem_rdata, input, DW: memory read data, valid MEM_LAT cycles after a read strobe.
- busy, output, 1: one or more reads are in flight.
- conflicts, output, 16: count of cycles where both requests were present and one lost.

Behaviour:
- Handshake:
  - A requester holds req, addr, we and wdata stable until it sees gnt high in the same cycle.
  - gnt is combinational from req, halt and the registered last-owner bit.
  - A transfer occurs on the edge where req and gnt are both high.
- Arbitration:
  - If only one requester asserts req and halt is low, it is granted.
  - If both assert req, the requester not granted last is granted.
  - The last-owner register updates on every grant. Reset value = L, so F wins the first conflict.
  - halt high forces f_gnt = l_gnt = 0 and leaves last-owner unchanged.
- Memory side (combinational from the granted request):
  - mem_en = f_gnt | l_gnt.
  - mem_we = l_gnt & l_we; F is always a read.
  - mem_addr and mem_wdata come from the granted requester.
  - When idle, mem_wdata = 0 and mem_addr = 0.
- Response tracking:
  - A MEM_LAT-deep shift pipeline records {valid, owner} for each issued read; writes enter valid = 0.
  - At the pipeline output, if valid, the owner's rvalid is high for exactly one cycle and its rdata = mem_rdata. The other rdata is 0.
  - Read latency from grant edge to rvalid = MEM_LAT cycles. Back-to-back grants give back-to-back rvalids in issue order.
- busy = OR of the pipeline valid bits; it is not affected by halt.
- Halt mid-flight: in-flight reads still complete and return rvalid.
- conflicts:
  - Increments on each cycle with f_req & l_req & !halt.
  - Saturates at 16'hFFFF and does not wrap.
- Reset (asynchronous, active low):
  - Clears the pipeline, last-owner (set to L) and conflicts.
  - All registered outputs go to 0 immediately: f_rvalid, l_rvalid, f_rdata, l_rdata, busy, conflicts.
  - Reads in flight at reset are discarded; no rvalid follows after reset deasserts.
  - Combinational grants are 0 while reset is low.
- A simultaneous grant and response in the same cycle is legal; the pipeline shifts every cycle.

Test Plan:
- F alone reads 0x0010, mem returns 0xBEEF, MEM_LAT=1 -> f_gnt high in cycle 0; f_rvalid high with f_rdata=0xBEEF in cycle 1; l_rvalid stays 0.
- F and L both request for 4 cycles, L load 0x0020 -> grants F, L, F, L; conflicts=2 after the first two granted cycles (both re-request, so conflicts=4 at the end); responses return in issue order.
- L store addr 0x0030, data 0x1234 -> mem_en=1, mem_we=1, mem_addr=0x0030, mem_wdata=0x1234; no l_rvalid in any later cycle.
- halt=1 while F reads with one read in flight, MEM_LAT=3 -> no new gnt; the in-flight read returns rvalid; busy falls 0 after the pipeline drains.
- Assert reset with two reads in flight -> busy=0 and conflicts=0 immediately; no rvalid after release; the next conflict grants F.
- Force 65536+ conflict cycles -> conflicts holds at 0xFFFF.
